// File: rtl/icache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned CPU_ADDR_W = 32;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned MEM_ADDR_W = 28;
    localparam int unsigned OFFSET_LSB = 2;
    localparam int unsigned BLOCK_LSB  = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Line storage: per-set valid/tag/data, combinational read, one write per edge.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned TAG_W    = 25
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(NUM_SETS)-1:0]  rd_index,
    output logic                         rd_valid,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [BLOCK_W-1:0]           rd_data,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_SETS)-1:0]  wr_index,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [BLOCK_W-1:0]           wr_data
);

    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [BLOCK_W-1:0]  data_mem [NUM_SETS];

    // Only valid bits are reset; stale tags/data are masked by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits, stall and
// whole-block refill from instruction memory on a miss.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  CPU_READ,
    input  logic [CPU_ADDR_W-1:0] CPU_ADDRESS,
    output logic [WORD_W-1:0]     CPU_INSTRUCTION,
    output logic                  CPU_BUSYWAIT,
    output logic                  MEM_READ,
    output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]    MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W   = MEM_ADDR_W - INDEX_W;

    state_t                  state_q, state_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0]      fill_q, fill_d;

    logic [MEM_ADDR_W-1:0]   cpu_block;
    logic [INDEX_W-1:0]      cpu_index;
    logic [TAG_W-1:0]        cpu_tag;
    logic [1:0]              cpu_offset;
    logic                    unused_addr_bits;

    logic                    line_valid;
    logic [TAG_W-1:0]        line_tag;
    logic [BLOCK_W-1:0]      line_data;
    logic                    line_wr_en;
    logic                    hit;
    logic [WORD_W-1:0]       hit_word;

    assign cpu_block        = CPU_ADDRESS[CPU_ADDR_W-1:BLOCK_LSB];
    assign cpu_index        = cpu_block[INDEX_W-1:0];
    assign cpu_tag          = cpu_block[MEM_ADDR_W-1:INDEX_W];
    assign cpu_offset       = CPU_ADDRESS[BLOCK_LSB-1:OFFSET_LSB];
    assign unused_addr_bits = ^CPU_ADDRESS[OFFSET_LSB-1:0];

    icache_line_array #(
        .NUM_SETS (NUM_SETS),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .rd_index (cpu_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (line_wr_en),
        .wr_index (mem_addr_q[INDEX_W-1:0]),
        .wr_tag   (mem_addr_q[MEM_ADDR_W-1:INDEX_W]),
        .wr_data  (fill_q)
    );

    assign hit         = CPU_READ & line_valid & (line_tag == cpu_tag);
    assign hit_word    = line_data[{cpu_offset, 5'b00000} +: WORD_W];
    assign MEM_ADDRESS = mem_addr_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            fill_q     <= fill_d;
        end
    end

    // Miss handling works only from the latched block address, so PC changes
    // during a refill cannot redirect it.
    always_comb begin
        state_d         = state_q;
        mem_addr_d      = mem_addr_q;
        fill_d          = fill_q;
        MEM_READ        = 1'b0;
        CPU_BUSYWAIT    = 1'b0;
        CPU_INSTRUCTION = '0;
        line_wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CPU_READ) begin
                    if (hit) begin
                        CPU_INSTRUCTION = hit_word;
                    end else begin
                        CPU_BUSYWAIT = 1'b1;
                        mem_addr_d   = cpu_block;
                        state_d      = S_MEM_READ;
                    end
                end
            end
            S_MEM_READ: begin
                MEM_READ     = 1'b1;
                CPU_BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill_d  = MEM_READDATA;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                CPU_BUSYWAIT = 1'b1;
                line_wr_en   = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache with a latency-programmable memory model.
module tb_instruction_cache;

    logic         CLOCK;
    logic         RESET_N;
    logic         CPU_READ;
    logic [31:0]  CPU_ADDRESS;
    logic [31:0]  CPU_INSTRUCTION;
    logic         CPU_BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int checks = 0;
    int errors = 0;
    int mem_lat = 5;
    int mem_cnt = 0;
    logic [31:0] exp_q[$];

    instruction_cache #(.NUM_SETS(8)) dut (
        .CLOCK           (CLOCK),
        .RESET_N         (RESET_N),
        .CPU_READ        (CPU_READ),
        .CPU_ADDRESS     (CPU_ADDRESS),
        .CPU_INSTRUCTION (CPU_INSTRUCTION),
        .CPU_BUSYWAIT    (CPU_BUSYWAIT),
        .MEM_READ        (MEM_READ),
        .MEM_ADDRESS     (MEM_ADDRESS),
        .MEM_READDATA    (MEM_READDATA),
        .MEM_BUSYWAIT    (MEM_BUSYWAIT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Block 0 holds the program words; other blocks are 0xC0000000 | blk<<8 | word.
    function automatic logic [127:0] block_data(input logic [27:0] blk);
        logic [127:0] d;
        if (blk == 28'd0) begin
            d = {32'h0000F613, 32'h0, 32'h0, 32'h8F108093};
        end else begin
            for (int w = 0; w < 4; w++)
                d[w*32 +: 32] = 32'hC000_0000 | (32'(blk) << 8) | 32'(w);
        end
        return d;
    endfunction

    assign MEM_READDATA = block_data(MEM_ADDRESS);
    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);

    always @(posedge CLOCK) begin
        if (!MEM_READ) mem_cnt <= 0;
        else           mem_cnt <= mem_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every delivered fetch is matched against the scoreboard queue.
    always @(negedge CLOCK) begin
        if (RESET_N && CPU_READ && !CPU_BUSYWAIT) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got %h expected nothing", CPU_INSTRUCTION);
            end else begin
                chk("instruction", CPU_INSTRUCTION, exp_q.pop_front());
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_word,
                         input bit exp_miss, input logic [27:0] exp_maddr,
                         input int lat, input int exp_busy);
        int  busy;
        bit  saw;
        bit  done;
        busy = 0; saw = 0; done = 0;
        @(posedge CLOCK); #1;
        mem_lat = lat;
        exp_q.push_back(exp_word);
        CPU_ADDRESS = addr;
        CPU_READ    = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLOCK);
            if (MEM_READ && !saw) begin
                saw = 1'b1;
                chk("mem_address", 32'(MEM_ADDRESS), 32'(exp_maddr));
            end
            if (!CPU_BUSYWAIT) done = 1'b1;
            else               busy++;
        end
        if (!done) begin
            errors++;
            $display("FAIL fetch_timeout: got busywait stuck expected release at addr %h", addr);
        end
        chk("busy_cycles", 32'(busy), 32'(exp_busy));
        chk("mem_read_seen", 32'(saw), 32'(exp_miss));
        @(posedge CLOCK); #1;
        CPU_READ = 1'b0;
    endtask

    initial begin
        int  busy;
        int  nreq;
        bit  prev_mr;
        bit  done;
        bit  change_pending;

        RESET_N     = 1'b0;
        CPU_READ    = 1'b0;
        CPU_ADDRESS = 32'h0;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_busywait", 32'(CPU_BUSYWAIT), 32'd0);
        chk("rst_mem_read", 32'(MEM_READ), 32'd0);
        chk("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
        chk("rst_instruction", CPU_INSTRUCTION, 32'd0);
        RESET_N = 1'b1;

        // Cold miss on block 0, then the remaining words hit.
        fetch(32'h0, 32'h8F108093, 1'b1, 28'h0, 5, 8);
        fetch(32'h4, 32'h0,        1'b0, 28'h0, 5, 0);
        fetch(32'h8, 32'h0,        1'b0, 28'h0, 5, 0);
        fetch(32'hC, 32'h0000F613, 1'b0, 28'h0, 5, 0);

        // Conflict in set 0 replaces the line; zero-latency memory on the re-read.
        fetch(32'h80, 32'hC0000800, 1'b1, 28'h8, 2, 5);
        fetch(32'h84, 32'hC0000801, 1'b0, 28'h8, 2, 0);
        fetch(32'h0,  32'h8F108093, 1'b1, 28'h0, 0, 3);

        // PC moves from 0x10 to 0x20 during the refill of block 1.
        @(posedge CLOCK); #1;
        mem_lat = 5;
        exp_q.push_back(32'hC0000200);
        CPU_ADDRESS = 32'h10;
        CPU_READ    = 1'b1;
        busy = 0; nreq = 0; prev_mr = 1'b0; done = 1'b0; change_pending = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge CLOCK);
            if (MEM_READ && !prev_mr) begin
                nreq++;
                if (nreq == 1) begin
                    chk("redirect_maddr1", 32'(MEM_ADDRESS), 32'h1);
                    change_pending = 1'b1;
                end else begin
                    chk("redirect_maddr2", 32'(MEM_ADDRESS), 32'h2);
                end
            end
            prev_mr = MEM_READ;
            if (!CPU_BUSYWAIT) done = 1'b1;
            else               busy++;
            if (change_pending) begin
                @(posedge CLOCK); #1;
                CPU_ADDRESS    = 32'h20;
                change_pending = 1'b0;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL redirect_timeout: got busywait stuck expected release");
        end
        chk("redirect_busy_cycles", 32'(busy), 32'd16);
        chk("redirect_requests", 32'(nreq), 32'd2);
        @(posedge CLOCK); #1;
        CPU_READ = 1'b0;
        fetch(32'h14, 32'hC0000101, 1'b0, 28'h1, 5, 0);

        // Reset asserted while a refill is outstanding.
        @(posedge CLOCK); #1;
        CPU_ADDRESS = 32'h30;
        CPU_READ    = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLOCK);
            if (MEM_READ) done = 1'b1;
        end
        chk("pre_reset_mem_read", 32'(MEM_READ), 32'd1);
        #1 RESET_N = 1'b0;
        #1;
        chk("midfill_rst_mem_read", 32'(MEM_READ), 32'd0);
        chk("midfill_rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
        CPU_READ = 1'b0;
        #1;
        chk("midfill_rst_busywait", 32'(CPU_BUSYWAIT), 32'd0);
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        fetch(32'h0, 32'h8F108093, 1'b1, 28'h0, 1, 4);

        // Idle with a valid line present.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            chk("idle_busywait", 32'(CPU_BUSYWAIT), 32'd0);
            chk("idle_mem_read", 32'(MEM_READ), 32'd0);
            chk("idle_instruction", CPU_INSTRUCTION, 32'd0);
        end
        fetch(32'h4, 32'h0, 1'b0, 28'h0, 5, 0);

        repeat (2) @(posedge CLOCK);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the CPU fetch stage and the instruction memory. Serves 32-bit instruction reads from the PC in the same cycle on a hit. On a miss it stalls the CPU, fetches the whole 128-bit block from instruction memory over the block-read busywait handshake, installs it, then completes the fetch.

## Interface
- NUM_SETS, 8, number of cache lines; power of two, ≥2; INDEX_W = log2(NUM_SETS)
- CLOCK  in  1  single clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CPU_READ  in  1  fetch request, level-sensitive
- CPU_ADDRESS  in  32  byte address (PC); bits [1:0] ignored
- CPU_INSTRUCTION  out  32  fetched word, valid when CPU_READ=1 and CPU_BUSYWAIT=0
- CPU_BUSYWAIT  out  1  stall to CPU
- MEM_READ  out  1  block-read request to instruction memory
- MEM_ADDRESS  out  28  block address, equal to the missing CPU_ADDRESS[31:4]
- MEM_READDATA  in  128  block; byte k at bits [8k+7:8k], word w at [32w+31:32w]
- MEM_BUSYWAIT  in  1  memory busy; goes high combinationally in the same cycle MEM_READ rises, low in the cycle MEM_READDATA is valid

## Operation
- Address split: offset = CPU_ADDRESS[3:2] (word in block), index = CPU_ADDRESS[INDEX_W+3:4], tag = CPU_ADDRESS[31:INDEX_W+4] (25 bits at default).
- Per line: valid bit, tag, 128-bit data.
- hit = CPU_READ & valid[index] & (tag_array[index] == tag); evaluated combinationally.
- FSM states IDLE, MEM_READ, UPDATE.
- IDLE:
  - hit: CPU_INSTRUCTION = selected word; CPU_BUSYWAIT=0.
  - CPU_READ & !hit: CPU_BUSYWAIT=1 combinationally. At the edge: latch CPU_ADDRESS[31:4] into MEM_ADDRESS, go to MEM_READ.
  - CPU_READ=0: CPU_BUSYWAIT=0; CPU_INSTRUCTION=0.
- MEM_READ: MEM_READ=1, MEM_ADDRESS held, CPU_BUSYWAIT=1.
  - Edge with MEM_BUSYWAIT=1: stay.
  - Edge with MEM_BUSYWAIT=0: capture MEM_READDATA into the fill buffer, go to UPDATE.
- UPDATE: MEM_READ=0, CPU_BUSYWAIT=1. At the edge, write fill buffer, tag (from latched address) and valid=1 into line latched-index, then go to IDLE.
- The miss line is chosen from the latched address. If CPU_ADDRESS changes during the miss, the fill completes unchanged and the new address is evaluated afresh in IDLE (may miss again).
- No writes from the CPU, no dirty state, no write-back.

## Timing
- Reset (async, immediate): state IDLE, all valid bits 0, MEM_READ=0, MEM_ADDRESS=0, fill buffer 0, CPU_BUSYWAIT=0 (CPU_READ low), CPU_INSTRUCTION=0. Tags and data are not reset.
- Reset mid-fill: MEM_READ drops immediately, the fill is abandoned, and no line is written.
- Hit latency: 0 cycles (combinational from CPU_ADDRESS).
- Miss with memory busy for N edges: CPU_BUSYWAIT is high for 1 (IDLE detect) + N + 1 (capture edge) + 1 (UPDATE) cycles. The word is delivered in the following IDLE cycle as a hit.
- MEM_READ is high exactly while in MEM_READ. It drops in the cycle after the capture edge.
- MEM_BUSYWAIT is ignored outside MEM_READ.
- A miss whose latched index equals a valid line's index overwrites that line (direct-mapped replacement).

## Structure
- Package icache_pkg:
  - state enum {IDLE, MEM_READ, UPDATE}
  - BLOCK_W=128, WORD_W=32, MEM_ADDR_W=28, OFFSET_LSB=2, BLOCK_LSB=4
- One sub-module: icache_line_array.
  - Contents: NUM_SETS×(valid, tag, data).
  - Read: combinational.
  - Write: single write port, one line per edge.
  - Reset: valid bits cleared asynchronously.
- Top level: FSM, hit compare, word mux, MEM_ADDRESS/fill registers.

## Test plan
- Reset then CPU_READ=1, CPU_ADDRESS=0x0000_0000; memory block 0 = {0x0000F613, 0, 0, 0x8F108093} (word3..word0), busy 5 edges:
  - MEM_READ=1 with MEM_ADDRESS=0x0000000.
  - CPU_BUSYWAIT high for 8 cycles.
  - Then CPU_INSTRUCTION=0x8F108093, busywait 0.
- After that fill, addresses 0x4, 0x8 and 0xC: each hits in 0 cycles with 0, 0, 0x0000F613. MEM_READ stays 0.
- Address 0x0000_0080 (same index 0, different tag): miss, MEM_ADDRESS=0x0000008, line replaced. A re-read of 0x0 then misses again.
- Change CPU_ADDRESS from 0x10 to 0x20 while in MEM_READ:
  - The fill for block 0x0000001 completes.
  - A second miss follows for 0x0000002.
- Assert RESET_N=0 during MEM_READ:
  - MEM_READ falls the same cycle.
  - After release, a read of the previously cached 0x0 misses.
- CPU_READ=0 with a valid line present: CPU_BUSYWAIT=0, MEM_READ=0, FSM stays IDLE.
